// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus stability-counter debouncer for a raw async input.
// Optional DEBOUNCE_EDGE_EN builds registered one-cycle rise/fall pulses; otherwise they are tied to 0.
module debounce_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 50000,
  parameter int   CNT_W       = 16,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dout;
  logic                   r_busy;

  logic             w_s;
  logic             w_mismatch;
  logic             w_update;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Any cycle of agreement drops all progress; reaching the last count commits the new level.
  always_comb begin
    w_mismatch = w_s ^ r_dout;
    w_update   = 1'b0;
    w_cnt_nxt  = '0;
    if (w_mismatch) begin
      if (r_cnt == LP_LAST) begin
        w_update = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_dout <= RST_VAL;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      if (w_update) begin
        r_dout <= w_s;
      end
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;

`ifdef DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_update & w_s;
      r_fall <= w_update & ~w_s;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
